// File: rtl/ysyx_201979054_div_sequencer.sv
// Multi-cycle restoring divider for DIVU/REMU/DIVUW/REMUW/DIVW, one quotient bit per cycle.
// Handshake: i_start is sampled only in IDLE; o_busy covers CALC and DONE; o_done is a one-cycle pulse with o_result valid.
module ysyx_201979054_div_sequencer #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_arst,
    input  logic            i_start,
    input  logic [4:0]      i_alu_control,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    input  logic            i_flush,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy,
    output logic            o_done,
    output logic [1:0]      o_dbg_state
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] OP_DIVU  = 5'b10101;
    localparam logic [4:0] OP_REMU  = 5'b10111;
    localparam logic [4:0] OP_DIVUW = 5'b10110;
    localparam logic [4:0] OP_REMUW = 5'b11000;
    localparam logic [4:0] OP_DIVW  = 5'b10011;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] div_q;
    logic [4:0]      op_q;
    logic            neg_q;
    logic [XLEN-1:0] result_q;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // Request decode and operand preparation
    logic            in_valid, in_w, in_rem, in_signed;
    logic [31:0]     a32, b32, a_mag, b_mag;
    logic [XLEN-1:0] eff_a, eff_b;
    logic            fast_zero, fast_ovf;
    logic [XLEN-1:0] fast_result;

    always_comb begin
        in_valid  = 1'b0;
        in_w      = 1'b0;
        in_rem    = 1'b0;
        in_signed = 1'b0;
        case (i_alu_control)
            OP_DIVU:  in_valid = 1'b1;
            OP_REMU:  begin in_valid = 1'b1; in_rem = 1'b1; end
            OP_DIVUW: begin in_valid = 1'b1; in_w = 1'b1; end
            OP_REMUW: begin in_valid = 1'b1; in_w = 1'b1; in_rem = 1'b1; end
            OP_DIVW:  begin in_valid = 1'b1; in_w = 1'b1; in_signed = 1'b1; end
            default:  in_valid = 1'b0;
        endcase

        a32   = i_src_a[31:0];
        b32   = i_src_b[31:0];
        a_mag = (in_signed && a32[31]) ? (~a32 + 32'd1) : a32;
        b_mag = (in_signed && b32[31]) ? (~b32 + 32'd1) : b32;
        eff_a = in_w ? {{(XLEN-32){1'b0}}, a_mag} : i_src_a;
        eff_b = in_w ? {{(XLEN-32){1'b0}}, b_mag} : i_src_b;

        fast_zero = (eff_b == '0);
        fast_ovf  = in_signed && (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);

        if (fast_ovf)
            fast_result = sext32(32'h8000_0000);
        else if (in_rem)
            fast_result = in_w ? sext32(a32) : i_src_a;
        else
            fast_result = '1;
    end

    // One restoring step; the borrow out of the subtraction is the compare
    logic [XLEN:0]   t, diff;
    logic            ge;
    logic [XLEN-1:0] rem_nxt, quo_nxt;
    logic [31:0]     q32;
    logic [XLEN-1:0] calc_result;

    always_comb begin
        t       = {rem, quo[XLEN-1]};
        diff    = t - {1'b0, div_q};
        ge      = ~diff[XLEN];
        rem_nxt = ge ? diff[XLEN-1:0] : t[XLEN-1:0];
        quo_nxt = {quo[XLEN-2:0], ge};
        q32     = neg_q ? (~quo_nxt[31:0] + 32'd1) : quo_nxt[31:0];
        case (op_q)
            OP_REMU:  calc_result = rem_nxt;
            OP_DIVUW: calc_result = sext32(quo_nxt[31:0]);
            OP_REMUW: calc_result = sext32(rem_nxt[31:0]);
            OP_DIVW:  calc_result = sext32(q32);
            default:  calc_result = quo_nxt;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            div_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else if (i_flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start && in_valid) begin
                        op_q  <= i_alu_control;
                        neg_q <= in_signed && (a32[31] ^ b32[31]);
                        div_q <= eff_b;
                        if (fast_zero || fast_ovf) begin
                            result_q <= fast_result;
                            state    <= S_DONE;
                        end else begin
                            // W dividends sit in the top half so quo[XLEN-1] is always the next bit
                            rem   <= '0;
                            quo   <= in_w ? {eff_a[31:0], {(XLEN-32){1'b0}}} : eff_a;
                            cnt   <= in_w ? CW'(31) : CW'(XLEN-1);
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    if (cnt == '0) begin
                        result_q <= calc_result;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_result    = result_q;
    assign o_busy      = (state != S_IDLE);
    assign o_done      = (state == S_DONE);
    assign o_dbg_state = state;

endmodule

// File: doc/ysyx_201979054_div_sequencer.md
# ysyx_201979054_div_sequencer

Multi-cycle sequencer for the divide/remainder ALU operations (DIVU, REMU, DIVUW, REMUW, DIVW). It sits beside the single-cycle ALU in the execute stage. On a start request it captures the operands and the 5-bit ALU control code, runs an iterative restoring divider at one quotient bit per cycle, and returns a final result with a one-cycle done pulse. It holds `o_busy` high so the control unit stalls the pipeline while the divide runs.

## Interface
- `XLEN`, 64: datapath width. W-ops always use 32-bit operands.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_arst`  in  1  asynchronous reset, active-high.
- `i_start`  in  1  request. Sampled only in IDLE.
- `i_alu_control`  in  5  operation code: 10101 DIVU, 10111 REMU, 10110 DIVUW, 11000 REMUW, 10011 DIVW.
- `i_src_a`  in  XLEN  dividend.
- `i_src_b`  in  XLEN  divisor.
- `i_flush`  in  1  synchronous abort. Has priority over everything except reset.
- `o_result`  out  XLEN  quotient or remainder. Valid while `o_done`=1 and held until the next accepted start.
- `o_busy`  out  1  high in CALC and DONE.
- `o_done`  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: waits for a request.
  - CALC: iterates one quotient bit per cycle.
  - DONE: presents the result.
- Accepted request: `i_start`=1 in IDLE and `i_alu_control` is one of the five codes.
  - Any other code is ignored: the block stays in IDLE and no pulse is produced.
  - Operands and code are latched on the accept edge. Later input changes have no effect.
- Operand preparation:
  - Unsigned 64-bit ops use the operands as-is.
  - DIVUW/REMUW use bits [31:0], zero-extended.
  - DIVW uses the magnitudes of the signed 32-bit operands. The quotient sign is the XOR of the operand sign bits.
- Fast paths: IDLE goes straight to DONE, skipping CALC.
  - Divisor (effective width) is zero:
    - Quotient is all ones (64-bit ops), or 0xFFFF_FFFF sign-extended (W-ops).
    - Remainder is the effective dividend, sign-extended from bit 31 for W-ops.
  - DIVW with dividend 0x8000_0000 and divisor 0xFFFF_FFFF: result is 0xFFFF_FFFF_8000_0000.
- Otherwise IDLE → CALC with the iteration counter loaded to N-1 (N = 64, or 32 for W-ops).
- CALC step, using registers rem (N+1 bits), quo (N bits) and the latched divisor:
  - t = {rem[N-1:0], quo[N-1]}; quo shifts left by one.
  - If t ≥ divisor: rem = t − divisor and quo[0] = 1. Else rem = t and quo[0] = 0.
  - When counter = 0, go to DONE; otherwise decrement the counter.
- DONE → IDLE unconditionally after one cycle.
- Result selection:
  - Quotient for DIVU/DIVUW/DIVW, remainder for REMU/REMUW.
  - DIVW negates the quotient when the sign bit is set.
  - All W results are sign-extended from bit 31 to XLEN.
- Flush in any state forces IDLE on the next edge. No `o_done` is produced and `o_result` keeps its previous value.

## Timing
- Reset values: state=IDLE, `o_result`=0, `o_busy`=0, `o_done`=0, counter=0, rem=0, quo=0.
- Reset asserted mid-operation aborts immediately. No done pulse follows after release.
- Latency from the accept edge (cycle 0) to the cycle in which `o_done`=1:
  - 64-bit ops: 65 cycles.
  - W-ops: 33 cycles.
  - Fast paths: 1 cycle.
- `o_busy` rises the cycle after accept and falls the cycle after DONE. The block can accept again in the first IDLE cycle after DONE.
- `i_start` held across CALC/DONE is ignored; it is re-sampled in IDLE. The control unit deasserts it on `o_done`. If it stays asserted, a second operation starts.
- `i_flush` and `i_start` in the same IDLE cycle: the flush wins and nothing is accepted.
- `i_flush` in the DONE cycle: `o_done` is still 1 in that cycle (it is registered state), and the block returns to IDLE.

## Test plan
- DIVU a=100, b=7 → `o_done` at cycle 65, `o_result`=14. Repeat with REMU → `o_result`=2.
- DIVW a=0xFFFF_FFF9 (−7), b=2 → `o_done` at cycle 33, `o_result`=0xFFFF_FFFF_FFFF_FFFD.
- DIVUW b=0 → `o_done` at cycle 1, `o_result`=0xFFFF_FFFF_FFFF_FFFF. REMUW a=0x8000_0005, b=0 → 0xFFFF_FFFF_8000_0005.
- DIVW a=0x8000_0000, b=0xFFFF_FFFF → cycle 1, `o_result`=0xFFFF_FFFF_8000_0000.
- DIVU 0xFFFF_FFFF_FFFF_FFFF / 1:
  - Toggle `i_start` and the operands at cycle 10; this has no effect.
  - Flush at cycle 20 → IDLE at cycle 21, no `o_done`.
  - A new REMUW a=0xFFFF_FFFF, b=0x10 accepted at cycle 21 → `o_done` at cycle 54, `o_result`=0xF.
- Start with `i_alu_control`=00000 → `o_busy` and `o_done` stay 0. Assert `i_arst` at cycle 30 of a DIVU → all outputs 0 immediately.
